// File: rtl/adder_digit_serial.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | adder_digit_serial                                                          |
// | WIDTH-bit a + b + c_in evaluated DIGIT bits per clock behind valid/ready.   |
// | Optional signed-overflow output selected by macro SIGNED_OVF_EN.            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module adder_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("adder_digit_serial: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
`ifdef SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [31:0]      lsb;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_full;
  logic [WIDTH-1:0] acc_next;
  logic             last_digit;

  // Operands stay put; the current digit is selected by shifting right by cnt*DIGIT.
  assign lsb        = 32'(cnt_q) * 32'(DIGIT);
  assign a_dig      = DIGIT'(a_q >> lsb);
  assign b_dig      = DIGIT'(b_q >> lsb);
  assign dig_full   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  // acc is cleared at accept, so each digit slot is written exactly once by OR.
  assign acc_next   = acc_q | (WIDTH'(dig_full[DIGIT-1:0]) << lsb);
  assign last_digit = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_next;
        carry_d = dig_full[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) begin
          sum_d   = acc_next;
          c_out_d = dig_full[DIGIT];
`ifdef SIGNED_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef SIGNED_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_digit_serial.sv
`default_nettype none
// Randomised + directed bench for adder_digit_serial (WIDTH=16, DIGIT=4) against
// a cycle-count arithmetic model; SIGNED_OVF_EN also enables ovf checking.
module tb_adder_digit_serial;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  adder_digit_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: an accepted operation becomes visible N edges later; result shown until handoff.
  bit           m_pending;
  int           m_edge;
  int           m_done;
  logic [W:0]   m_total;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      m_edge    = 0;
      m_done    = 0;
      m_sum     = '0;
      m_cout    = 1'b0;
      m_ovf     = 1'b0;
    end else begin
      m_edge++;
      if (!m_pending) begin
        if (in_valid) begin
          m_pending = 1'b1;
          m_done    = m_edge + N;
          m_a       = a;
          m_b       = b;
          m_total   = (W+1)'(a) + (W+1)'(b) + (W+1)'(c_in);
        end
      end else if (m_edge == m_done) begin
        m_sum  = m_total[W-1:0];
        m_cout = m_total[W];
        m_ovf  = (m_a[W-1] == m_b[W-1]) && (m_total[W-1] != m_a[W-1]);
      end else if (m_edge > m_done && out_ready) begin
        m_pending = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !m_pending);
      check("out_valid", out_valid, m_pending && (m_edge >= m_done));
      check("sum", sum, m_sum);
      check("c_out", c_out, m_cout);
`ifdef SIGNED_OVF_EN
      check("ovf", ovf, m_ovf);
`endif
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1; a = xa; b = xb; c_in = xc;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, N);
    check("lit_sum", sum, es);
    check("lit_c_out", c_out, ec);
`ifdef SIGNED_OVF_EN
    check("lit_ovf", ovf, eo);
`endif
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      @(posedge clk); #1;
      check("hold_sum", sum, es);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_valid", out_valid, 1'b0);
    check("handoff_ready", in_ready, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_c_out", c_out, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    op(16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    op(16'h0009, 16'h0009, 1'b0, 16'h0012, 1'b0, 1'b0);

    // Reset two cycles after an accept discards the operation.
    wait_ready();
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; c_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, 16'h0000);
    check("midrst_c_out", c_out, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(16'd10, 16'd5, 1'b1, 16'd16, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0: begin a = 16'hFFFF; b = W'($urandom_range(1)); end
        1: begin a = 16'h7FFF; b = 16'h8000 | W'($urandom_range(3)); end
        default: begin a = W'($urandom); b = W'($urandom); end
      endcase
      c_in = 1'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
